// File: rtl/digit_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module   : digit_serial_addsub
// Purpose  : Multi-cycle ripple-carry adder/subtractor. Each RUN cycle handles
//            DIGIT bits, least significant digit first. The carry between
//            digits is held in a flop. Both sides use a valid/ready handshake.
// Ports    : clk, rst_n (synchronous, active low)
//            in_valid/in_ready   - operand handshake (a, b, sub, c_in)
//            out_valid/out_ready - result handshake (sum, c_out, ovf)
//            sub = 1 gives A - B - c_in; for sub, c_out = 1 means no borrow
//            ovf                 - two's-complement signed overflow
// Revision : 1.0 - initial release
// ============================================================================
module digit_serial_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int                 c_N     = WIDTH / DIGIT;
    localparam int                 c_CNT_W = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(c_N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state_q, w_state_d;
    logic [WIDTH-1:0]     r_a_q,     w_a_d;
    logic [WIDTH-1:0]     r_b_q,     w_b_d;
    logic [WIDTH-1:0]     r_res_q,   w_res_d;
    logic [WIDTH-1:0]     r_sum_q,   w_sum_d;
    logic                 r_carry_q, w_carry_d;
    logic                 r_c_out_q, w_c_out_d;
    logic                 r_ovf_q,   w_ovf_d;
    logic [c_CNT_W-1:0]   r_cnt_q,   w_cnt_d;

    logic [DIGIT-1:0]       w_dsum;      // digit sum of current RUN cycle
    logic [DIGIT:0]         w_dc;        // carries inside the digit chain
    logic [WIDTH+DIGIT-1:0] w_res_cat;   // new digit placed above the result

    // DIGIT-bit ripple chain on the low digit of the operand shift registers.
    always_comb begin
        w_dc    = '0;
        w_dsum  = '0;
        w_dc[0] = r_carry_q;
        for (int i = 0; i < DIGIT; i++) begin
            w_dsum[i]  = r_a_q[i] ^ r_b_q[i] ^ w_dc[i];
            w_dc[i+1]  = (r_a_q[i] & r_b_q[i]) | (w_dc[i] & (r_a_q[i] ^ r_b_q[i]));
        end
    end

    // The digit enters from the MSB side. Taking the top WIDTH bits of the
    // concatenation does the shift and also covers DIGIT == WIDTH.
    assign w_res_cat = {w_dsum, r_res_q};

    always_comb begin
        w_state_d = r_state_q;
        w_a_d     = r_a_q;
        w_b_d     = r_b_q;
        w_res_d   = r_res_q;
        w_sum_d   = r_sum_q;
        w_carry_d = r_carry_q;
        w_c_out_d = r_c_out_q;
        w_ovf_d   = r_ovf_q;
        w_cnt_d   = r_cnt_q;

        case (r_state_q)
            S_IDLE: begin
                if (in_valid) begin
                    w_a_d     = a;
                    // Subtraction is A + ~B + ~c_in. This makes c_out read
                    // as "no borrow".
                    w_b_d     = sub ? ~b : b;
                    w_carry_d = c_in ^ sub;
                    w_cnt_d   = '0;
                    w_state_d = S_RUN;
                end
            end
            S_RUN: begin
                w_a_d     = r_a_q >> DIGIT;
                w_b_d     = r_b_q >> DIGIT;
                w_res_d   = w_res_cat[WIDTH+DIGIT-1:DIGIT];
                w_carry_d = w_dc[DIGIT];
                w_cnt_d   = r_cnt_q + 1'b1;
                if (r_cnt_q == c_LAST) begin
                    // The visible result only changes once the final digit is in.
                    w_sum_d   = w_res_cat[WIDTH+DIGIT-1:DIGIT];
                    w_c_out_d = w_dc[DIGIT];
                    w_ovf_d   = w_dc[DIGIT] ^ w_dc[DIGIT-1];
                    w_state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_d = S_IDLE;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q <= S_IDLE;
            r_a_q     <= '0;
            r_b_q     <= '0;
            r_res_q   <= '0;
            r_sum_q   <= '0;
            r_carry_q <= 1'b0;
            r_c_out_q <= 1'b0;
            r_ovf_q   <= 1'b0;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_a_q     <= w_a_d;
            r_b_q     <= w_b_d;
            r_res_q   <= w_res_d;
            r_sum_q   <= w_sum_d;
            r_carry_q <= w_carry_d;
            r_c_out_q <= w_c_out_d;
            r_ovf_q   <= w_ovf_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

    assign in_ready  = (r_state_q == S_IDLE);
    assign out_valid = (r_state_q == S_DONE);
    assign sum       = r_sum_q;
    assign c_out     = r_c_out_q;
    assign ovf       = r_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_digit_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module   : tb_digit_serial_addsub
// Purpose  : Self-checking bench for digit_serial_addsub.
//            - Main instance (16/4): directed cases, backpressure, reset
//              mid-operation and random cases.
//            - Sweep instances (16/1, 16/16, 8/2): random add/sub cases.
//            A signed/unsigned arithmetic reference model supplies the
//            expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_digit_serial_addsub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst_sw_n;
    logic        in_valid, in_ready, sub, c_in, out_valid, out_ready, c_out, ovf;
    logic [15:0] a, b, sum;

    int n_checks = 0;
    int n_errors = 0;

    digit_serial_addsub #(.WIDTH(16), .DIGIT(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .c_in(c_in), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .c_out(c_out), .ovf(ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model. Packs the expected result as {ovf, c_out, sum}, with
    // c_out at bit w and ovf at bit w+1. The values come from unsigned and
    // signed integer arithmetic.
    function automatic logic [31:0] ref_model(input int w, input longint ua, input longint ub,
                                              input bit s, input bit ci);
        longint m, half, t, sa, sb, sr;
        bit     co, ov;
        m    = 1;
        m    = m << w;
        half = m / 2;
        sa   = (ua >= half) ? ua - m : ua;
        sb   = (ub >= half) ? ub - m : ub;
        if (!s) begin
            t  = ua + ub + longint'(ci);
            co = (t >= m);
            sr = sa + sb + longint'(ci);
        end else begin
            t  = ua - ub - longint'(ci);
            co = (t >= 0);
            sr = sa - sb - longint'(ci);
            t  = t + m;
        end
        t  = t % m;
        ov = (sr >= half) || (sr < -half);
        return 32'(t) | (32'(co) << w) | (32'(ov) << (w + 1));
    endfunction

    // Issue one operation with out_ready high. Returns the output latency
    // (counted in edges after the accept edge), the number of sampled cycles
    // with in_ready low, and the packed result.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts,
                          input logic tc, output int lat, output int busy,
                          output logic [31:0] res);
        int k;
        bit seen;
        k = 0; seen = 0; lat = -1; busy = 0; res = '0;
        @(negedge clk);
        a = ta; b = tb_v; sub = ts; c_in = tc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!in_ready && k < 60) begin
            busy++;
            if (out_valid && !seen) begin
                seen = 1;
                lat  = k;
                res  = {14'd0, ovf, c_out, sum};
            end
            @(posedge clk); #1;
            k++;
        end
        if (k >= 60) check("op_timeout", 32'd1, 32'd0);
    endtask

    task automatic directed(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                            input logic ts, input logic tc, input logic [31:0] exp);
        int lat, busy;
        logic [31:0] res;
        run_op(ta, tb_v, ts, tc, lat, busy, res);
        check({tag, "_res"}, res, exp);
        check({tag, "_lat"}, lat, 32'd4);
        check({tag, "_busy"}, busy, 32'd5);
    endtask

    // ---------------- parameter sweep instances ----------------
    initial begin
        rst_sw_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_sw_n = 1'b1;
    end

    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int W = (g == 2) ? 8 : 16;
        localparam int D = (g == 0) ? 1 : (g == 1) ? 16 : 2;
        localparam int N = W / D;
        logic [W-1:0] sa, sb, ssum;
        logic         ssub, sci, siv, sir, sov, sco, sovf;
        bit           done = 0;

        digit_serial_addsub #(.WIDTH(W), .DIGIT(D)) u_dut (
            .clk(clk), .rst_n(rst_sw_n), .in_valid(siv), .in_ready(sir),
            .a(sa), .b(sb), .sub(ssub), .c_in(sci), .out_valid(sov),
            .out_ready(1'b1), .sum(ssum), .c_out(sco), .ovf(sovf)
        );

        initial begin
            logic [31:0] r, exp, got;
            int k;
            siv = 1'b0; sa = '0; sb = '0; ssub = 1'b0; sci = 1'b0;
            repeat (6) @(negedge clk);
            for (int i = 0; i < 1000; i++) begin
                @(negedge clk);
                r = $urandom; sa = r[W-1:0];
                r = $urandom; sb = r[W-1:0];
                r = $urandom; ssub = r[0]; sci = r[1];
                siv = 1'b1;
                @(posedge clk); #1;
                siv = 1'b0;
                k = 0;
                while (!sov && k < 100) begin
                    @(posedge clk); #1;
                    k++;
                end
                got = '0;
                got[W+1:0] = {sovf, sco, ssum};
                exp = ref_model(W, longint'(sa), longint'(sb), ssub, sci);
                check("sweep_lat", k, N);
                check("sweep_res", got, exp);
                @(posedge clk); #1;
            end
            done = 1;
        end
    end

    // ---------------- main directed / random sequence ----------------
    initial begin
        int          k, lat, busy, w;
        logic [31:0] r, res, exp;
        logic [15:0] ra, rb;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; sub = 1'b0; c_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 32'd1);
        check("rst_out_valid", out_valid, 32'd0);
        check("rst_sum", sum, 32'd0);
        check("rst_c_out", c_out, 32'd0);
        check("rst_ovf", ovf, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        directed("add_basic", 16'h1234, 16'h0001, 1'b0, 1'b0, 32'h0_1235);
        directed("add_ripple", 16'hFFFF, 16'h0000, 1'b0, 1'b1, 32'h1_0000);
        directed("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 32'h2_8000);
        directed("sub_neg", 16'h0005, 16'h0007, 1'b1, 1'b0, 32'h0_FFFE);
        directed("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b0, 32'h3_7FFF);
        directed("sub_bin", 16'h0010, 16'h0003, 1'b1, 1'b1, 32'h1_000C);

        // Backpressure: the result must hold and in_valid must be ignored.
        out_ready = 1'b0;
        @(negedge clk);
        a = 16'h0003; b = 16'h0004; sub = 1'b0; c_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("bp_valid", out_valid, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            r = $urandom; a = r[15:0]; b = r[31:16]; sub = r[0]; in_valid = 1'b1;
            @(posedge clk); #1;
            check("bp_hold", {14'd0, ovf, c_out, sum}, 32'h0_0007);
            check("bp_in_ready", in_ready, 32'd0);
            check("bp_valid_hold", out_valid, 32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1; a = 16'h0100; b = 16'h0020; sub = 1'b1; c_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        check("bp_release_ready", in_ready, 32'd1);
        check("bp_release_valid", out_valid, 32'd0);
        check("bp_release_sum", sum, 32'h0007);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_accept", in_ready, 32'd0);
        k = 0;
        while (!out_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("bp_next_lat", k, 32'd4);
        check("bp_next_res", {14'd0, ovf, c_out, sum}, 32'h1_00E0);
        @(posedge clk); #1;

        // Reset during the second RUN cycle.
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; sub = 1'b0; c_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_valid", out_valid, 32'd0);
        check("mid_rst_sum", sum, 32'd0);
        check("mid_rst_ready", in_ready, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        directed("post_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 32'h0_0100);

        // Random cases on the main instance.
        for (int i = 0; i < 300; i++) begin
            r = $urandom; ra = r[15:0]; rb = r[31:16];
            r = $urandom;
            exp = ref_model(16, longint'(ra), longint'(rb), r[0], r[1]);
            run_op(ra, rb, r[0], r[1], lat, busy, res);
            check("rand_res", res, exp);
            check("rand_lat", lat, 32'd4);
        end

        w = 0;
        while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done) && w < 60000) begin
            @(posedge clk);
            w++;
        end
        if (w >= 60000) check("sweep_timeout", 32'd1, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
